kernel_window_former: RTL and testbench

Consumer end of the row buffer system: it reads the steered row-buffer column plus the live external pixel and assembles a KERNEL_SIZE x KERNEL_SIZE sliding window for the convolution datapath. It sits directly after the steering stage. It tracks raster position, suppresses windows that are incomplete at the top and left borders, and flags frame completion and protocol errors.

---
 rtl/rb_pkg.sv | 15 +
 rtl/window_shift_reg.sv | 36 +++
 rtl/kernel_window_former.sv | 106 ++++++++++
 tb/tb_kernel_window_former.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/rb_pkg.sv
// Shared defaults and helpers for the row-buffer / window-forming path.
package rb_pkg;
  localparam int PIXEL_BITS   = 8;
  localparam int IMAGE_WIDTH  = 512;
  localparam int IMAGE_HEIGHT = 512;
  localparam int KERNEL_SIZE  = 5;
  localparam int RB_COUNT     = KERNEL_SIZE - 1;
  localparam int COL_W        = $clog2(IMAGE_WIDTH);
  localparam int ROW_W        = $clog2(IMAGE_HEIGHT);

  // Bit offset of window element (r,c); r=0 is top row, c=0 is left column.
  function automatic int win_off(input int r, input int c, input int k, input int pb);
    return (r * k + c) * pb;
  endfunction
endpackage

// File: rtl/window_shift_reg.sv
// K x K column shift register; a load shifts every column left and appends col_i on the right.
module window_shift_reg import rb_pkg::*; #(
  parameter int PIXEL_BITS  = rb_pkg::PIXEL_BITS,
  parameter int KERNEL_SIZE = rb_pkg::KERNEL_SIZE
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       load_i,
  input  logic [PIXEL_BITS*KERNEL_SIZE-1:0]             col_i,
  output logic [PIXEL_BITS*KERNEL_SIZE*KERNEL_SIZE-1:0] win_d_o
);
  logic [PIXEL_BITS*KERNEL_SIZE*KERNEL_SIZE-1:0] win_q, win_d;

  always_comb begin
    win_d = win_q;
    if (load_i) begin
      for (int r = 0; r < KERNEL_SIZE; r++) begin
        for (int c = 0; c < KERNEL_SIZE; c++) begin
          if (c < KERNEL_SIZE - 1)
            win_d[win_off(r, c, KERNEL_SIZE, PIXEL_BITS) +: PIXEL_BITS] =
              win_q[win_off(r, c + 1, KERNEL_SIZE, PIXEL_BITS) +: PIXEL_BITS];
          else
            win_d[win_off(r, c, KERNEL_SIZE, PIXEL_BITS) +: PIXEL_BITS] =
              col_i[r*PIXEL_BITS +: PIXEL_BITS];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) win_q <= '0;
    else     win_q <= win_d;
  end

  assign win_d_o = win_d;
endmodule

// File: rtl/kernel_window_former.sv
// Assembles a K x K sliding window from the steered row-buffer column plus the live pixel,
// tracking raster position and gating out windows incomplete at the top/left borders.
module kernel_window_former import rb_pkg::*; #(
  parameter int PIXEL_BITS   = rb_pkg::PIXEL_BITS,
  parameter int IMAGE_WIDTH  = rb_pkg::IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT = rb_pkg::IMAGE_HEIGHT,
  parameter int KERNEL_SIZE  = rb_pkg::KERNEL_SIZE,
  parameter int RB_COUNT     = KERNEL_SIZE - 1
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic [PIXEL_BITS-1:0]                      live_pixel,
  input  logic                                       live_valid,
  input  logic                                       frame_start,
  input  logic [PIXEL_BITS*RB_COUNT-1:0]             rb_data,
  input  logic [RB_COUNT-1:0]                        rb_valid,
  output logic [PIXEL_BITS*KERNEL_SIZE*KERNEL_SIZE-1:0] win_data,
  output logic                                       win_valid,
  output logic [$clog2(IMAGE_HEIGHT)-1:0]            win_row,
  output logic [$clog2(IMAGE_WIDTH)-1:0]             win_col,
  output logic                                       frame_done,
  output logic                                       protocol_err
);
  localparam int RW   = $clog2(IMAGE_HEIGHT);
  localparam int CW   = $clog2(IMAGE_WIDTH);
  localparam int WB   = PIXEL_BITS * KERNEL_SIZE * KERNEL_SIZE;
  localparam int HALF = (KERNEL_SIZE - 1) / 2;

  localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_EDGE = RW'(KERNEL_SIZE - 1);
  localparam logic [RW-1:0] ROW_HALF = RW'(HALF);
  localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);
  localparam logic [CW-1:0] COL_EDGE = CW'(KERNEL_SIZE - 1);
  localparam logic [CW-1:0] COL_HALF = CW'(HALF);

  logic [CW-1:0] col_q, col_d, pos_col;
  logic [RW-1:0] row_q, row_d, pos_row;
  logic          win_hit, last_px, rb_bad;
  logic [WB-1:0] shift_next;
  logic [WB-1:0] win_data_q;
  logic          win_valid_q, frame_done_q, protocol_err_q;
  logic [RW-1:0] win_row_q;
  logic [CW-1:0] win_col_q;

  window_shift_reg #(
    .PIXEL_BITS  (PIXEL_BITS),
    .KERNEL_SIZE (KERNEL_SIZE)
  ) u_shift (
    .clk     (clk),
    .rst     (rst),
    .load_i  (live_valid),
    .col_i   ({live_pixel, rb_data}),
    .win_d_o (shift_next)
  );

  // frame_start overrides the counters so the accepted pixel is raster (0,0).
  always_comb begin
    pos_col = frame_start ? '0 : col_q;
    pos_row = frame_start ? '0 : row_q;
    col_d   = col_q;
    row_d   = row_q;
    if (live_valid) begin
      if (pos_col == COL_LAST) begin
        col_d = '0;
        row_d = (pos_row == ROW_LAST) ? '0 : pos_row + 1'b1;
      end else begin
        col_d = pos_col + 1'b1;
        row_d = pos_row;
      end
    end
    win_hit = live_valid && (pos_row >= ROW_EDGE) && (pos_col >= COL_EDGE);
    last_px = live_valid && (pos_row == ROW_LAST) && (pos_col == COL_LAST);
    rb_bad  = live_valid && (pos_row >= ROW_EDGE) && !(&rb_valid);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q          <= '0;
      row_q          <= '0;
      win_data_q     <= '0;
      win_valid_q    <= 1'b0;
      win_row_q      <= '0;
      win_col_q      <= '0;
      frame_done_q   <= 1'b0;
      protocol_err_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_valid_q  <= win_hit;
      frame_done_q <= last_px;
      if (rb_bad) protocol_err_q <= 1'b1;
      if (win_hit) begin
        win_data_q <= shift_next;
        win_row_q  <= pos_row - ROW_HALF;
        win_col_q  <= pos_col - COL_HALF;
      end
    end
  end

  assign win_data     = win_data_q;
  assign win_valid    = win_valid_q;
  assign win_row      = win_row_q;
  assign win_col      = win_col_q;
  assign frame_done   = frame_done_q;
  assign protocol_err = protocol_err_q;
endmodule

// File: tb/tb_kernel_window_former.sv
// Randomised directed bench for kernel_window_former (K=3, 8x8 frames) against an image-array model.
module tb_kernel_window_former;
  localparam int PB = 8;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int K  = 3;
  localparam int RB = K - 1;
  localparam int RW = $clog2(H);
  localparam int CW = $clog2(W);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [PB-1:0]       live_pixel;
  logic                live_valid;
  logic                frame_start;
  logic [PB*RB-1:0]    rb_data;
  logic [RB-1:0]       rb_valid;
  logic [PB*K*K-1:0]   win_data;
  logic                win_valid;
  logic [RW-1:0]       win_row;
  logic [CW-1:0]       win_col;
  logic                frame_done;
  logic                protocol_err;

  kernel_window_former #(
    .PIXEL_BITS   (PB),
    .IMAGE_WIDTH  (W),
    .IMAGE_HEIGHT (H),
    .KERNEL_SIZE  (K),
    .RB_COUNT     (RB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .live_pixel   (live_pixel),
    .live_valid   (live_valid),
    .frame_start  (frame_start),
    .rb_data      (rb_data),
    .rb_valid     (rb_valid),
    .win_data     (win_data),
    .win_valid    (win_valid),
    .win_row      (win_row),
    .win_col      (win_col),
    .frame_done   (frame_done),
    .protocol_err (protocol_err)
  );

  int tests = 0;
  int fails = 0;

  // Model state: the frame as an image, the raster position of the next pixel, expected outputs.
  logic [PB-1:0]     img [H][W];
  int                mr, mc;
  logic [PB*K*K-1:0] exp_data;
  logic [RW-1:0]     exp_row;
  logic [CW-1:0]     exp_col;
  logic              exp_err;
  int                win_cnt, done_cnt;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs(input bit ev, input bit ed);
    chk("win_valid",    128'(win_valid),    128'(ev));
    chk("frame_done",   128'(frame_done),   128'(ed));
    chk("protocol_err", 128'(protocol_err), 128'(exp_err));
    chk("win_data",     128'(win_data),     128'(exp_data));
    chk("win_row",      128'(win_row),      128'(exp_row));
    chk("win_col",      128'(win_col),      128'(exp_col));
  endtask

  task automatic send(input bit fs, input bit pattern, input bit bad);
    int pr, pc;
    bit ev, ed;
    logic [PB-1:0] pix;
    if (fs) begin mr = 0; mc = 0; end
    pr  = mr;
    pc  = mc;
    pix = pattern ? PB'((pr * W + pc) % 256) : PB'($urandom);
    @(negedge clk);
    live_valid  = 1'b1;
    frame_start = fs;
    live_pixel  = pix;
    for (int r = 0; r < RB; r++) begin
      if (pr >= K - 1) rb_data[r*PB +: PB] = img[pr-(K-1)+r][pc];
      else             rb_data[r*PB +: PB] = PB'($urandom);
    end
    rb_valid = bad ? RB'($urandom_range(0, (1 << RB) - 2)) : {RB{1'b1}};
    img[pr][pc] = pix;
    ev = (pr >= K - 1) && (pc >= K - 1);
    ed = (pr == H - 1) && (pc == W - 1);
    if (bad && pr >= K - 1) exp_err = 1'b1;
    if (ev) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          exp_data[(r*K+c)*PB +: PB] = img[pr-(K-1)+r][pc-(K-1)+c];
      exp_row = RW'(pr - (K - 1) / 2);
      exp_col = CW'(pc - (K - 1) / 2);
    end
    if (pc == W - 1) begin
      mc = 0;
      mr = (pr == H - 1) ? 0 : pr + 1;
    end else begin
      mc = pc + 1;
    end
    @(posedge clk);
    #1;
    if (win_valid)  win_cnt++;
    if (frame_done) done_cnt++;
    check_outputs(ev, ed);
  endtask

  task automatic idle();
    @(negedge clk);
    live_valid  = 1'b0;
    frame_start = 1'($urandom);
    live_pixel  = PB'($urandom);
    rb_data     = (PB*RB)'($urandom);
    rb_valid    = RB'($urandom);
    @(posedge clk);
    #1;
    if (win_valid)  win_cnt++;
    if (frame_done) done_cnt++;
    check_outputs(1'b0, 1'b0);
  endtask

  task automatic run(input int n, input bit fs_first, input int gap, input bit pattern,
                     input int bad_a, input int bad_b);
    for (int i = 0; i < n; i++) begin
      send(fs_first && (i == 0), pattern, (i == bad_a) || (i == bad_b));
      if (gap == 1) idle();
      else if (gap == 2 && $urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) idle();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    live_valid  = 1'b0;
    frame_start = 1'b0;
    rst         = 1'b1;
    #1;
    exp_data = '0;
    exp_row  = '0;
    exp_col  = '0;
    exp_err  = 1'b0;
    check_outputs(1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_outputs(1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    mr  = 0;
    mc  = 0;
  endtask

  initial begin
    rst         = 1'b1;
    live_valid  = 1'b0;
    frame_start = 1'b0;
    live_pixel  = '0;
    rb_data     = '0;
    rb_valid    = '0;
    mr = 0; mc = 0;
    exp_data = '0; exp_row = '0; exp_col = '0; exp_err = 1'b0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = '0;
    do_reset();

    // Continuous frame with the (row*8+col) pattern.
    win_cnt = 0; done_cnt = 0;
    run(H * W, 1'b1, 0, 1'b1, -1, -1);
    chk("frame1_windows", 128'(win_cnt), 128'((H - K + 1) * (W - K + 1)));
    chk("frame1_done",    128'(done_cnt), 128'(1));

    // Random pixels, live_valid toggling every cycle.
    win_cnt = 0; done_cnt = 0;
    run(H * W, 1'b1, 1, 1'b0, -1, -1);
    chk("frame2_windows", 128'(win_cnt), 128'((H - K + 1) * (W - K + 1)));
    chk("frame2_done",    128'(done_cnt), 128'(1));

    // Abort at (3,7) with frame_start, then a full frame from the restart.
    win_cnt = 0; done_cnt = 0;
    run(3 * W + 7, 1'b1, 2, 1'b0, -1, -1);
    run(H * W, 1'b1, 2, 1'b0, -1, -1);
    chk("restart_windows", 128'(win_cnt), 128'(11 + (H - K + 1) * (W - K + 1)));
    chk("restart_done",    128'(done_cnt), 128'(1));

    // Bad rb_valid at row 1 (ignored) and at row 4 (sticky error).
    win_cnt = 0; done_cnt = 0;
    run(H * W, 1'b1, 2, 1'b0, W + 2, 4 * W + 1);
    repeat (3) idle();
    chk("perr_windows", 128'(win_cnt), 128'((H - K + 1) * (W - K + 1)));
    chk("perr_sticky",  128'(protocol_err), 128'(1));

    // Reset mid-frame at (5,5), then a frame without frame_start.
    run(5 * W + 5, 1'b1, 2, 1'b0, -1, -1);
    do_reset();
    win_cnt = 0; done_cnt = 0;
    run(H * W, 1'b0, 2, 1'b0, -1, -1);
    repeat (2) idle();
    chk("post_reset_windows", 128'(win_cnt), 128'((H - K + 1) * (W - K + 1)));
    chk("post_reset_done",    128'(done_cnt), 128'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
